// File: rtl/pe_load_seq_pkg.sv
// Shared types and helpers for the PE load sequencer: FSM state encoding,
// count width and the run-command legality check.
package eyeriss_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOADW,
    S_GAPW,
    S_LOADA,
    S_GAPA,
    S_START,
    S_WAIT,
    S_SUMS,
    S_FIN
  } pe_seq_state_t;

  // A run needs at least one weight and one activation, both within the
  // scratchpads, and never more weights than activations.
  function automatic logic cmd_ok(input logic [CNT_W-1:0] w, input logic [CNT_W-1:0] a,
                                  input int w_max, input int a_max);
    return (w != '0) && (a != '0) && (int'(w) <= w_max) && (int'(a) <= a_max) && (w <= a);
  endfunction

endpackage

// File: rtl/pe_load_seq_if.sv
// Command, stream and PE-control bus of the sequencer; slave is the sequencer
// side, master is whoever drives commands/streams and models the PE.
interface pe_load_seq_if #(
  parameter int dataSize = 8
);
  import eyeriss_pkg::*;

  logic                 cmd_start_i;
  logic [CNT_W-1:0]     cmd_wcount_i;
  logic [CNT_W-1:0]     cmd_acount_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;
  logic [dataSize-1:0]  w_data_i;
  logic                 w_valid_i;
  logic                 w_ready_o;
  logic [dataSize-1:0]  a_data_i;
  logic                 a_valid_i;
  logic                 a_ready_o;
  logic [dataSize-1:0]  pe_weights_o;
  logic [dataSize-1:0]  pe_acts_o;
  logic                 pe_loadw_o;
  logic                 pe_loada_o;
  logic [CNT_W-1:0]     pe_wcount_o;
  logic [CNT_W-1:0]     pe_acount_o;
  logic                 pe_start_o;
  logic                 pe_sums_o;
  logic                 pe_done_i;

  modport slave (
    input  cmd_start_i, cmd_wcount_i, cmd_acount_i,
    input  w_data_i, w_valid_i, a_data_i, a_valid_i, pe_done_i,
    output busy_o, done_o, err_o, w_ready_o, a_ready_o,
    output pe_weights_o, pe_acts_o, pe_loadw_o, pe_loada_o,
    output pe_wcount_o, pe_acount_o, pe_start_o, pe_sums_o
  );

  modport master (
    output cmd_start_i, cmd_wcount_i, cmd_acount_i,
    output w_data_i, w_valid_i, a_data_i, a_valid_i, pe_done_i,
    input  busy_o, done_o, err_o, w_ready_o, a_ready_o,
    input  pe_weights_o, pe_acts_o, pe_loadw_o, pe_loada_o,
    input  pe_wcount_o, pe_acount_o, pe_start_o, pe_sums_o
  );

endinterface

// File: rtl/pe_load_seq_stream_load_cnt.sv
// Accepts exactly `target` beats from a valid/ready stream after `start`,
// re-registering each beat as a one-cycle load strobe plus data.
module stream_load_cnt
  import eyeriss_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [CNT_W-1:0] target,
  input  logic [DW-1:0]    data,
  input  logic             valid,
  output logic             ready,
  output logic             last,
  output logic [DW-1:0]    q_data,
  output logic             q_load
);

  logic [CNT_W-1:0] cnt;
  logic             fire;

  assign fire = valid & ready;
  assign last = fire && ((cnt + CNT_W'(1)) == target);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt    <= '0;
      ready  <= 1'b0;
      q_data <= '0;
      q_load <= 1'b0;
    end else begin
      q_load <= fire;
      if (fire) q_data <= data;
      if (start) begin
        cnt   <= '0;
        ready <= 1'b1;
      end else if (fire) begin
        cnt <= cnt + CNT_W'(1);
        if (last) ready <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pe_load_seq.sv
// Per-PE sequencer: loads weights, then activations, starts the PE, waits for
// flag_done (with timeout) and opens the psum pass-through window.
module pe_load_seq
  import eyeriss_pkg::*;
#(
  parameter int dataSize    = 8,
  parameter int wSpadNReg   = 16,
  parameter int aSpadNReg   = 16,
  parameter int doneTimeout = 1000000
) (
  input  logic              clk,
  input  logic              nrst,
  pe_load_seq_if.slave      bus
);

  localparam int TW = $clog2(doneTimeout + 1);
  localparam int SW = CNT_W + 1;

  pe_seq_state_t state, next_state;
  logic [SW-1:0] sums_cnt;
  logic [TW-1:0] tcnt;
  logic          accept, reject, done_seen, timeout;
  logic          w_last, a_last;

  stream_load_cnt #(.DW(dataSize)) u_wload (
    .clk    (clk),
    .nrst   (nrst),
    .start  (accept),
    .target (bus.pe_wcount_o),
    .data   (bus.w_data_i),
    .valid  (bus.w_valid_i),
    .ready  (bus.w_ready_o),
    .last   (w_last),
    .q_data (bus.pe_weights_o),
    .q_load (bus.pe_loadw_o)
  );

  stream_load_cnt #(.DW(dataSize)) u_aload (
    .clk    (clk),
    .nrst   (nrst),
    .start  (state == S_GAPW),
    .target (bus.pe_acount_o),
    .data   (bus.a_data_i),
    .valid  (bus.a_valid_i),
    .ready  (bus.a_ready_o),
    .last   (a_last),
    .q_data (bus.pe_acts_o),
    .q_load (bus.pe_loada_o)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    done_seen  = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cmd_start_i) begin
          if (cmd_ok(bus.cmd_wcount_i, bus.cmd_acount_i, wSpadNReg, aSpadNReg)) begin
            accept     = 1'b1;
            next_state = S_LOADW;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_LOADW: if (w_last) next_state = S_GAPW;
      S_GAPW:  next_state = S_LOADA;
      S_LOADA: if (a_last) next_state = S_GAPA;
      S_GAPA:  next_state = S_START;
      S_START: next_state = S_WAIT;
      S_WAIT: begin
        // The first WAIT cycle coincides with pe_start_o, so done is stale there.
        if (tcnt != '0 && bus.pe_done_i) begin
          done_seen  = 1'b1;
          next_state = S_SUMS;
        end else if (tcnt == TW'(doneTimeout - 1)) begin
          timeout    = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_SUMS:  if (sums_cnt == SW'(1)) next_state = S_FIN;
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus.busy_o      <= 1'b0;
      bus.done_o      <= 1'b0;
      bus.err_o       <= 1'b0;
      bus.pe_start_o  <= 1'b0;
      bus.pe_sums_o   <= 1'b0;
      bus.pe_wcount_o <= '0;
      bus.pe_acount_o <= '0;
      sums_cnt        <= '0;
      tcnt            <= '0;
    end else begin
      bus.busy_o     <= (next_state != S_IDLE);
      bus.done_o     <= (state == S_FIN);
      bus.err_o      <= reject | timeout;
      bus.pe_start_o <= (state == S_START);
      bus.pe_sums_o  <= (state == S_SUMS);
      if (accept) begin
        bus.pe_wcount_o <= bus.cmd_wcount_i;
        bus.pe_acount_o <= bus.cmd_acount_i;
      end
      // Window length acount+1-wcount is at least 1 because wcount <= acount.
      if (done_seen)
        sums_cnt <= SW'(bus.pe_acount_o) + SW'(1) - SW'(bus.pe_wcount_o);
      else if (state == S_SUMS)
        sums_cnt <= sums_cnt - SW'(1);
      tcnt <= (state == S_WAIT) ? tcnt + TW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_pe_load_seq.sv
// Directed bench for pe_load_seq: command-legality table plus full-run
// sequences covering stalls, ignored commands, timeout and mid-run reset.
module tb_pe_load_seq;
  import eyeriss_pkg::*;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  pe_load_seq_if #(.dataSize(8)) bus();

  pe_load_seq #(
    .dataSize    (8),
    .wSpadNReg   (16),
    .aSpadNReg   (16),
    .doneTimeout (100)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [7:0] w;
    logic [7:0] a;
    logic       err;
    logic       busy;
  } cmd_vec_t;

  // Run trackers, cycle numbers counted from 1 = first cycle after the command.
  int lw_n, lw_first, lw_last, la_n, la_first, la_last;
  int st_n, st_first, su_n, su_first, su_last, dn_cyc, er_cyc;
  int busy_gap, busy_at_end, timed_out;
  logic [7:0] wq[$];
  logic [7:0] aq[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.cmd_start_i  = 1'b0;
    bus.cmd_wcount_i = '0;
    bus.cmd_acount_i = '0;
    bus.w_data_i     = '0;
    bus.w_valid_i    = 1'b0;
    bus.a_data_i     = '0;
    bus.a_valid_i    = 1'b0;
    bus.pe_done_i    = 1'b0;
  endtask

  task automatic do_reset;
    nrst = 1'b0;
    idle_inputs();
    tick();
    tick();
    nrst = 1'b1;
    tick();
  endtask

  // wmode 0: weight valid always high; 1: valid on odd cycles only.
  // done_dly: pe_done pulse that many cycles after pe_start (0 = never).
  // inject: cycle at which a second command (w=2,a=2) is driven (-1 = none).
  // rst_sums: assert nrst after that many pe_sums cycles (0 = never).
  // noise: pulse pe_done where it must be ignored (cycle 10 and the pe_start cycle).
  task automatic run(input int w, input int a, input int wmode, input int done_dly,
                     input int inject, input int rst_sums, input int noise);
    int  cyc, wi, ai;
    logic fin, wh, ah;
    lw_n = 0; lw_first = -1; lw_last = -1;
    la_n = 0; la_first = -1; la_last = -1;
    st_n = 0; st_first = -1; su_n = 0; su_first = -1; su_last = -1;
    dn_cyc = -1; er_cyc = -1; busy_gap = 0; busy_at_end = -1; timed_out = 0;
    wq.delete();
    aq.delete();
    bus.cmd_start_i  = 1'b1;
    bus.cmd_wcount_i = 8'(w);
    bus.cmd_acount_i = 8'(a);
    tick();
    bus.cmd_start_i = 1'b0;
    cyc = 1; wi = 0; ai = 0; fin = 1'b0;
    while (!fin) begin
      if (bus.pe_loadw_o) begin
        lw_n++; lw_last = cyc; if (lw_first < 0) lw_first = cyc;
        wq.push_back(bus.pe_weights_o);
      end
      if (bus.pe_loada_o) begin
        la_n++; la_last = cyc; if (la_first < 0) la_first = cyc;
        aq.push_back(bus.pe_acts_o);
      end
      if (bus.pe_start_o) begin
        st_n++; if (st_first < 0) st_first = cyc;
      end
      if (bus.pe_sums_o) begin
        su_n++; su_last = cyc; if (su_first < 0) su_first = cyc;
      end
      if (bus.done_o) begin
        dn_cyc = cyc; busy_at_end = int'(bus.busy_o); fin = 1'b1;
      end else if (bus.err_o) begin
        er_cyc = cyc; busy_at_end = int'(bus.busy_o); fin = 1'b1;
      end else if (rst_sums > 0 && su_n == rst_sums) begin
        nrst = 1'b0;
        #1;
        fin = 1'b1;
      end else if (cyc >= 400) begin
        timed_out = 1; fin = 1'b1;
      end else begin
        if (!bus.busy_o) busy_gap++;
        bus.w_valid_i   = (wmode == 0) ? 1'b1 : logic'(cyc % 2);
        bus.w_data_i    = 8'(16 + wi);
        bus.a_valid_i   = 1'b1;
        bus.a_data_i    = 8'(128 + ai);
        bus.pe_done_i   = (done_dly > 0 && st_first > 0 && cyc == st_first + done_dly) ||
                          (noise != 0 && (cyc == 10 || cyc == st_first));
        bus.cmd_start_i = (cyc == inject);
        if (cyc == inject) begin
          bus.cmd_wcount_i = 8'd2;
          bus.cmd_acount_i = 8'd2;
        end
        wh = bus.w_valid_i & bus.w_ready_o;
        ah = bus.a_valid_i & bus.a_ready_o;
        tick();
        if (wh) wi++;
        if (ah) ai++;
        cyc++;
      end
    end
    bus.cmd_start_i = 1'b0;
    bus.pe_done_i   = 1'b0;
  endtask

  initial begin
    cmd_vec_t tbl[8];
    tbl[0] = '{w: 8'd0,  a: 8'd5,  err: 1'b1, busy: 1'b0};
    tbl[1] = '{w: 8'd17, a: 8'd17, err: 1'b1, busy: 1'b0};
    tbl[2] = '{w: 8'd5,  a: 8'd4,  err: 1'b1, busy: 1'b0};
    tbl[3] = '{w: 8'd3,  a: 8'd0,  err: 1'b1, busy: 1'b0};
    tbl[4] = '{w: 8'd1,  a: 8'd17, err: 1'b1, busy: 1'b0};
    tbl[5] = '{w: 8'd1,  a: 8'd1,  err: 1'b0, busy: 1'b1};
    tbl[6] = '{w: 8'd16, a: 8'd16, err: 1'b0, busy: 1'b1};
    tbl[7] = '{w: 8'd4,  a: 8'd9,  err: 1'b0, busy: 1'b1};

    idle_inputs();
    #2;
    check("reset_ctrl", {bus.busy_o, bus.done_o, bus.err_o, bus.w_ready_o, bus.a_ready_o,
                         bus.pe_loadw_o, bus.pe_loada_o, bus.pe_start_o, bus.pe_sums_o}, 0);
    check("reset_data", {bus.pe_weights_o, bus.pe_acts_o, bus.pe_wcount_o, bus.pe_acount_o}, 0);
    do_reset();

    // Full run w=3,a=16, streams always valid, stray pe_done pulses outside the sample window.
    run(3, 16, 0, 5, -1, 0, 1);
    check("t1_budget", timed_out, 0);
    check("t1_loadw_n", lw_n, 3);
    check("t1_loadw_first", lw_first, 2);
    check("t1_loadw_last", lw_last, 4);
    check("t1_loada_n", la_n, 16);
    check("t1_loada_first", la_first, 6);
    check("t1_loada_last", la_last, 21);
    check("t1_start_n", st_n, 1);
    check("t1_start_cyc", st_first, 23);
    check("t1_sums_n", su_n, 14);
    check("t1_sums_first", su_first, 30);
    check("t1_sums_last", su_last, 43);
    check("t1_done_cyc", dn_cyc, 44);
    check("t1_err", er_cyc, -1);
    check("t1_busy_gap", busy_gap, 0);
    check("t1_busy_at_done", busy_at_end, 0);
    check("t1_wq_size", wq.size(), 3);
    if (wq.size() == 3) begin
      check("t1_w0", wq[0], 8'h10);
      check("t1_w2", wq[2], 8'h12);
    end
    if (aq.size() == 16) begin
      check("t1_a0", aq[0], 8'h80);
      check("t1_a15", aq[15], 8'h8f);
    end
    check("t1_wcount_hold", bus.pe_wcount_o, 3);
    check("t1_acount_hold", bus.pe_acount_o, 16);

    // Weight valid toggling: loadw follows each accepted beat one cycle later.
    run(3, 4, 1, 2, -1, 0, 0);
    check("t2_budget", timed_out, 0);
    check("t2_loadw_n", lw_n, 3);
    check("t2_loadw_first", lw_first, 2);
    check("t2_loadw_last", lw_last, 6);
    check("t2_wq_size", wq.size(), 3);
    if (wq.size() == 3) begin
      check("t2_w0", wq[0], 8'h10);
      check("t2_w1", wq[1], 8'h11);
      check("t2_w2", wq[2], 8'h12);
    end
    check("t2_loada_first", la_first, 8);
    check("t2_loada_n", la_n, 4);
    check("t2_start_cyc", st_first, 13);
    check("t2_sums_n", su_n, 2);
    check("t2_done_cyc", dn_cyc, 19);

    // Command legality table.
    for (int i = 0; i < 8; i++) begin
      bus.cmd_start_i  = 1'b1;
      bus.cmd_wcount_i = tbl[i].w;
      bus.cmd_acount_i = tbl[i].a;
      tick();
      bus.cmd_start_i = 1'b0;
      check($sformatf("t3_v%0d_err", i), bus.err_o, tbl[i].err);
      check($sformatf("t3_v%0d_busy", i), bus.busy_o, tbl[i].busy);
      check($sformatf("t3_v%0d_wready", i), bus.w_ready_o, tbl[i].busy);
      check($sformatf("t3_v%0d_aready", i), bus.a_ready_o, 0);
      if (tbl[i].busy) check($sformatf("t3_v%0d_wcount", i), bus.pe_wcount_o, tbl[i].w);
      tick();
      check($sformatf("t3_v%0d_err_pulse", i), bus.err_o, 0);
      check($sformatf("t3_v%0d_busy2", i), bus.busy_o, tbl[i].busy);
      if (tbl[i].busy) do_reset();
    end

    // Second command during LOADA is ignored.
    run(3, 5, 0, 2, 7, 0, 0);
    check("t4_budget", timed_out, 0);
    check("t4_err", er_cyc, -1);
    check("t4_loadw_n", lw_n, 3);
    check("t4_loada_n", la_n, 5);
    check("t4_start_cyc", st_first, 12);
    check("t4_sums_n", su_n, 3);
    check("t4_done_cyc", dn_cyc, 19);
    check("t4_wcount", bus.pe_wcount_o, 3);
    check("t4_acount", bus.pe_acount_o, 5);

    // WAIT timeout with pe_done held low.
    run(2, 2, 0, 0, -1, 0, 0);
    check("t5_budget", timed_out, 0);
    check("t5_start_cyc", st_first, 8);
    check("t5_err_cyc", er_cyc, 108);
    check("t5_done", dn_cyc, -1);
    check("t5_sums_n", su_n, 0);
    check("t5_busy_at_err", busy_at_end, 0);
    bus.pe_done_i = 1'b1;
    tick();
    bus.pe_done_i = 1'b0;
    tick();
    check("t5_idle_sums", bus.pe_sums_o, 0);
    check("t5_idle_busy", bus.busy_o, 0);
    run(1, 1, 0, 1, -1, 0, 0);
    check("t5_after_done", dn_cyc, 10);
    check("t5_after_sums", su_n, 1);

    // Reset in the middle of SUMS, then a minimal run and back-to-back command.
    run(1, 8, 0, 3, -1, 3, 0);
    check("t6_reached_sums", su_n, 3);
    check("t6_rst_ctrl", {bus.busy_o, bus.done_o, bus.err_o, bus.w_ready_o, bus.a_ready_o,
                          bus.pe_loadw_o, bus.pe_loada_o, bus.pe_start_o, bus.pe_sums_o}, 0);
    check("t6_rst_data", {bus.pe_weights_o, bus.pe_acts_o, bus.pe_wcount_o, bus.pe_acount_o}, 0);
    idle_inputs();
    tick();
    nrst = 1'b1;
    tick();
    run(1, 1, 0, 1, -1, 0, 0);
    check("t6_budget", timed_out, 0);
    check("t6_sums_n", su_n, 1);
    check("t6_sums_first", su_first, 9);
    check("t6_done_cyc", dn_cyc, 10);
    bus.cmd_start_i  = 1'b1;
    bus.cmd_wcount_i = 8'd2;
    bus.cmd_acount_i = 8'd3;
    tick();
    bus.cmd_start_i = 1'b0;
    check("t6_b2b_busy", bus.busy_o, 1);
    check("t6_b2b_wcount", bus.pe_wcount_o, 2);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
